// File: rtl/washmech_plant_model.sv
// Plant/sensor model for the washing-machine controller loop: turns actuator
// commands into door, water-level, timer and dispenser sensor responses, and
// records sticky fault flags for illegal actuator combinations.
`timescale 1ns/1ps
module washmech_plant_model #(
  parameter int LEVEL_W    = 8,
  parameter int FULL_LEVEL = 200,
  parameter int WASH_TICKS = 50,
  parameter int SPIN_TICKS = 30,
  parameter int DET_TICKS  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_open_req,
  input  logic               door_shut_req,
  input  logic               door_lock,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               motor_on,
  input  logic               soap_wash,
  output logic               door_close,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         fault
);

  localparam int WASH_W = $clog2(WASH_TICKS + 1);
  localparam int SPIN_W = $clog2(SPIN_TICKS + 1);
  localparam int DET_W  = $clog2(DET_TICKS + 1);

  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FULL_LEVEL);
  localparam logic [WASH_W-1:0]  WASH_MAX   = WASH_W'(WASH_TICKS);
  localparam logic [SPIN_W-1:0]  SPIN_MAX   = SPIN_W'(SPIN_TICKS);
  localparam logic [DET_W-1:0]   DET_LAST   = DET_W'(DET_TICKS - 1);

  typedef enum logic [1:0] {
    D_IDLE     = 2'd0,
    D_DISPENSE = 2'd1,
    D_DONE     = 2'd2
  } det_state_t;

  logic               door_close_q, door_close_d;
  logic [LEVEL_W-1:0] level_q,      level_d;
  logic [WASH_W-1:0]  wash_cnt_q,   wash_cnt_d;
  logic [SPIN_W-1:0]  spin_cnt_q,   spin_cnt_d;
  logic [DET_W-1:0]   det_cnt_q,    det_cnt_d;
  det_state_t         det_state_q,  det_state_d;
  logic [2:0]         fault_q,      fault_d;

  logic at_full;
  logic at_empty;

  // Level bounds decoded from the register so sensors track level with no lag.
  assign at_full  = (level_q == LEVEL_FULL);
  assign at_empty = (level_q == '0);

  // Door latch: an open request wins over shut, but only while unlocked.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    door_close_d = door_close_q;
    if (door_open_req && !door_lock) begin
      door_close_d = 1'b0;
    end else if (door_shut_req) begin
      door_close_d = 1'b1;
    end
  end

  // Water level: fill or drain alone moves it one step, saturating at the bounds.
  always_comb begin
    level_d = level_q;
    unique case ({fill_value_on, drain_value_on})
      2'b10:   if (!at_full)  level_d = level_q + LEVEL_W'(1);
      2'b01:   if (!at_empty) level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Wash/spin timers: count with motor at full/empty, hold at partial, clear with motor off.
  always_comb begin
    wash_cnt_d = wash_cnt_q;
    spin_cnt_d = spin_cnt_q;
    if (!motor_on) begin
      wash_cnt_d = '0;
      spin_cnt_d = '0;
    end else begin
      if (at_full && (wash_cnt_q != WASH_MAX)) wash_cnt_d = wash_cnt_q + WASH_W'(1);
      if (at_empty && (spin_cnt_q != SPIN_MAX)) spin_cnt_d = spin_cnt_q + SPIN_W'(1);
    end
  end

  // Detergent dispenser: starts on soap request at full level, aborts if soap drops early.
  always_comb begin
    det_state_d = det_state_q;
    det_cnt_d   = det_cnt_q;
    unique case (det_state_q)
      D_IDLE: begin
        if (soap_wash && at_full) begin
          det_state_d = D_DISPENSE;
          det_cnt_d   = '0;
        end
      end
      D_DISPENSE: begin
        if (!soap_wash) begin
          det_state_d = D_IDLE;
          det_cnt_d   = '0;
        end else if (det_cnt_q == DET_LAST) begin
          det_state_d = D_DONE;
        end else begin
          det_cnt_d = det_cnt_q + DET_W'(1);
        end
      end
      D_DONE: begin
        if (!soap_wash) begin
          det_state_d = D_IDLE;
          det_cnt_d   = '0;
        end
      end
      default: begin
        det_state_d = D_IDLE;
        det_cnt_d   = '0;
      end
    endcase
  end

  // Sticky fault flags; they only report and never feed back into the plant.
  always_comb begin
    fault_d    = fault_q;
    fault_d[0] = fault_q[0] | ((fill_value_on | drain_value_on | motor_on) & ~door_lock);
    fault_d[1] = fault_q[1] | (fill_value_on & drain_value_on);
    fault_d[2] = fault_q[2] | (motor_on & ~at_full & ~at_empty);
  end

  // State registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      door_close_q <= 1'b0;
      level_q      <= '0;
      wash_cnt_q   <= '0;
      spin_cnt_q   <= '0;
      det_cnt_q    <= '0;
      det_state_q  <= D_IDLE;
      fault_q      <= '0;
    end else begin
      door_close_q <= door_close_d;
      level_q      <= level_d;
      wash_cnt_q   <= wash_cnt_d;
      spin_cnt_q   <= spin_cnt_d;
      det_cnt_q    <= det_cnt_d;
      det_state_q  <= det_state_d;
      fault_q      <= fault_d;
    end
  end

  assign door_close      = door_close_q;
  assign filled          = at_full;
  assign drained         = at_empty;
  assign detergent_added = (det_state_q == D_DONE);
  assign cycle_timeout   = (wash_cnt_q == WASH_MAX);
  assign spin_timeout    = (spin_cnt_q == SPIN_MAX);
  assign level           = level_q;
  assign fault           = fault_q;

endmodule
